// File: rtl/kernel_cnn_mul_arbiter.sv
// rtl/kernel_cnn_mul_arbiter.sv - round-robin arbiter sharing one 13x6 multiplier among NUM_REQ requesters
// Optional grant counter built only when MUL_ARB_STATS_EN is defined.
module kernel_cnn_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 13,
    parameter int B_WIDTH  = 6,
    parameter int P_WIDTH  = 19,
    parameter int ID_WIDTH = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [P_WIDTH-1:0]          res_data,
    output logic [ID_WIDTH-1:0]         res_id,
    output logic                        busy,
    output logic [31:0]                 stat_grants
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [P_WIDTH-1:0]  res_data_q, res_data_d;

    logic [A_WIDTH-1:0]  a_arr [NUM_REQ];
    logic [B_WIDTH-1:0]  b_arr [NUM_REQ];
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] cand;
    logic                any_valid;
    logic                can_accept;
    logic                xfer;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*A_WIDTH +: A_WIDTH];
        assign b_arr[i] = req_b[i*B_WIDTH +: B_WIDTH];
    end

    // Scan from the farthest candidate back to rr_ptr so the nearest asserted bit wins.
    always_comb begin
        grant     = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    // Reset gates ready so no requester sees a handshake while the block is held in reset.
    assign can_accept = (state_q == EMPTY) || res_ready;
    assign xfer       = any_valid && can_accept && ap_rst_n;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        if (xfer) begin
            state_d    = FULL;
            res_id_d   = grant;
            res_data_d = P_WIDTH'(a_arr[grant]) * P_WIDTH'(b_arr[grant]);
            rr_ptr_d   = (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_WIDTH'(1);
        end else if (state_q == FULL && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = res_valid || (|req_valid);

`ifdef MUL_ARB_STATS_EN
    logic [31:0] stat_grants_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_grants_q <= '0;
        end else if (xfer) begin
            stat_grants_q <= stat_grants_q + 32'd1;
        end
    end

    assign stat_grants = stat_grants_q;
`else
    assign stat_grants = 32'd0;
`endif

endmodule

// File: doc/kernel_cnn_mul_arbiter.md
# kernel_cnn_mul_arbiter

Round-robin arbiter and sequencer that shares one unsigned 13x6 multiplier among `NUM_REQ` requesters inside the CNN kernel. Each cycle it grants one pending requester and multiplies that requester's operands combinationally. The full-precision product is registered and returned on a single result channel, tagged with the requester index. The block sustains one multiply per cycle with one cycle of latency and supports backpressure on the result side.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `A_WIDTH`, 13: operand A width, unsigned.
- `B_WIDTH`, 6: operand B width, unsigned.
- `P_WIDTH`, 19: product width; must equal `A_WIDTH + B_WIDTH`.
- `ID_WIDTH`, 2: requester tag width; must equal clog2(`NUM_REQ`).

Ports:
- `ap_clk`  in  1: single clock, rising edge.
- `ap_rst_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ: bit i means requester i has operands pending.
- `req_ready`  out  NUM_REQ: bit i means requester i's operands are accepted this cycle; one-hot or zero.
- `req_a`  in  NUM_REQ*A_WIDTH: operand A; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- `req_b`  in  NUM_REQ*B_WIDTH: operand B, packed the same way as `req_a`.
- `res_valid`  out  1: result register holds a product.
- `res_ready`  in  1: downstream consumes the result this cycle.
- `res_data`  out  P_WIDTH: product.
- `res_id`  out  ID_WIDTH: index of the requester that issued the product.
- `busy`  out  1: `res_valid` OR any bit of `req_valid`.
- `stat_grants`  out  32: count of accepted requests (see Configuration).

## Operation
- **Can-accept:** `can_accept = !res_valid || res_ready`.
- **Arbitration:** round-robin over asserted `req_valid` bits. The search starts at pointer `rr_ptr` and wraps modulo `NUM_REQ`. The first asserted bit found is `grant`.
- **Ready:** `req_ready[grant] = can_accept` when any `req_valid` bit is set. All other `req_ready` bits are 0. `req_ready` may depend combinationally on `req_valid`.
- **Transfer:** a transfer occurs when `req_valid[i] && req_ready[i]`. On a transfer:
  - `res_data <= A_i * B_i`, unsigned, both operands zero-extended, full precision. The maximum product, 8191*63 = 516033, fits in 19 bits; no truncation and no saturation.
  - `res_id <= grant`.
  - `res_valid <= 1`.
  - `rr_ptr <= (grant + 1) mod NUM_REQ`.
- **No transfer:** `rr_ptr` holds.
- **Drain:** if `res_ready && res_valid` and there is no new transfer, `res_valid <= 0`. `res_data` and `res_id` keep their last values.
- **Simultaneous drain and accept:** the register is reloaded in the same cycle. There is no bubble.
- **Stall:** while `res_valid && !res_ready`, all `req_ready` bits are 0, and `res_data` and `res_id` are held stable.
- **Requester rules:** a requester holds `req_valid` and its operands until it sees `req_ready`. A requester may drop `req_valid` without penalty before it is granted.
- **State:** the block has two states, EMPTY (`res_valid` = 0) and FULL (`res_valid` = 1).
  - EMPTY goes to FULL on a transfer.
  - FULL stays FULL on a stall or on drain-and-accept.
  - FULL goes to EMPTY on drain with no transfer.

## Timing
- **Latency:** request accepted at edge t, so `res_valid` = 1 with the product after edge t.
- **Throughput:** one product per cycle when `res_ready` is held high.
- **Reset values** (`ap_rst_n` low, effective immediately and asynchronously):
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0, `rr_ptr` = 0.
  - `req_ready` = 0 throughout reset.
  - `stat_grants` = 0.
- **Reset mid-operation:** a held result is discarded. After release, requester 0 has first priority.
- **Fairness:** with all requesters continuously valid, grants follow 0,1,...,NUM_REQ-1,0,... A waiting requester is granted within `NUM_REQ` accepts.

## Configuration
- **`MUL_ARB_STATS_EN` defined:** `stat_grants` is a 32-bit counter that increments by 1 on every transfer and wraps from 0xFFFFFFFF to 0.
- **`MUL_ARB_STATS_EN` undefined:** the counter is not built and `stat_grants` is tied to 0. All other behaviour is identical.

## Test plan
- **Single request:** requester 2 with a=100, b=5, `res_ready`=1. Required: `req_ready`=4'b0100 for one cycle, then the next cycle shows `res_valid`=1, `res_data`=500, `res_id`=2.
- **Extreme operands:** a=8191, b=63 → `res_data`=516033. a=0, b=63 → `res_data`=0.
- **Full contention:** all 4 requesters valid continuously, `res_ready`=1, 8 cycles. Required: `res_id` sequence 0,1,2,3,0,1,2,3, with no idle cycles.
- **Backpressure:** result pending and `res_ready`=0 for 3 cycles. Required: `req_ready`=0, `res_data`/`res_id` stable, no request lost. When `res_ready` rises, drain and accept happen in the same cycle.
- **Reset mid-operation:** assert `ap_rst_n`=0 while `res_valid`=1 and requesters 1 and 3 are pending. Required: `res_valid` drops without waiting for a clock edge. After release, requester 1 is granted before requester 3.
- **Statistics:** with `MUL_ARB_STATS_EN` defined, 10 accepts give `stat_grants`=10. Without the macro, `stat_grants` stays 0.
